// File: rtl/rr_arbiter_mux.sv
// Round-robin N:1 arbiter + data mux with a registered valid/ready output stage.
// Define RR_ARBITER_MUX_IDX_EN to add out_idx_o, the index of the source of the held word.

module or_reduction #(
    parameter int N = 4,
    parameter int W = 64
) (
    input  logic [W-1:0] data_i [N],
    output logic [W-1:0] data_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives data_o and no latch is inferred.
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            data_o |= data_i[i];
        end
    end

endmodule

module rr_arbiter_mux #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [DATA_WIDTH-1:0] req_data_i [NUM_REQ],
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
`ifdef RR_ARBITER_MUX_IDX_EN
    ,
    output logic [$clog2(NUM_REQ)-1:0] out_idx_o
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      win;
    logic [NUM_REQ-1:0]    grant;
    logic [DATA_WIDTH-1:0] masked [NUM_REQ];
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  load;
    logic                  transfer;

    // Scan from the pointer upward with wrap; the first valid index wins.
    always_comb begin
        grant = '0;
        win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [PTR_W-1:0] idx;
            idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req_valid_i[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = grant[i] ? req_data_i[i] : '0;
        end
    end

    or_reduction #(
        .N (NUM_REQ),
        .W (DATA_WIDTH)
    ) u_or_reduction (
        .data_i (masked),
        .data_o (sel_data)
    );

    assign load        = !out_valid_o || out_ready_i;
    assign req_ready_o = grant & {NUM_REQ{load}};
    assign transfer    = |req_ready_o;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr_q       <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
`ifdef RR_ARBITER_MUX_IDX_EN
            out_idx_o   <= '0;
`endif
        end else if (load) begin
            out_valid_o <= |req_valid_i;
            if (transfer) begin
                out_data_o <= sel_data;
                ptr_q      <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef RR_ARBITER_MUX_IDX_EN
                out_idx_o  <= win;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Self-checking bench for rr_arbiter_mux (NUM_REQ=4, DATA_WIDTH=8): directed scenarios
// with literal expectations plus randomized traffic against a behavioural model.

module tb_rr_arbiter_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         arst_i;
    logic [W-1:0] req_data [N];
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef RR_ARBITER_MUX_IDX_EN
    logic [1:0]   out_idx;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model state: what the output register and priority pointer must hold.
    int           m_ptr;
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_idx;

    always #5 clk = ~clk;

    rr_arbiter_mux #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst_i),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
`ifdef RR_ARBITER_MUX_IDX_EN
        ,
        .out_idx_o   (out_idx)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // First valid requester at or after p, wrapping; -1 when none is valid.
    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int w;
        logic [N-1:0] r;
        r = '0;
        w = winner(req_valid, m_ptr);
        if ((!m_valid || out_ready) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_idx   = 0;
        end else if (!m_valid || out_ready) begin
            int w;
            w = winner(req_valid, m_ptr);
            m_valid = (w >= 0);
            if (w >= 0) begin
                m_data = req_data[w];
                m_idx  = w;
                m_ptr  = (w + 1) % N;
            end
        end
    end

    // Inputs change 2 time units after a rising edge, so the falling edge sees settled values.
    always @(negedge clk) begin
        check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
        check("cmp_out_data", 32'(out_data), 32'(m_data));
        check("cmp_req_ready", 32'(req_ready), 32'(model_ready()));
`ifdef RR_ARBITER_MUX_IDX_EN
        check("cmp_out_idx", 32'(out_idx), 32'(m_idx));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        arst_i = 1'b1;
        tick();
        arst_i = 1'b0;
    endtask

    task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        req_data[0] = d0;
        req_data[1] = d1;
        req_data[2] = d2;
        req_data[3] = d3;
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] d, input int idx);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, 32'(out_data), 32'(d));
`ifdef RR_ARBITER_MUX_IDX_EN
        check({name, "_idx"}, 32'(out_idx), 32'(idx));
`else
        if (idx < 0) $display("unexpected index %0d", idx);
`endif
    endtask

    logic [W-1:0] rot [5];
    logic [W-1:0] alt [4];

    initial begin
        rot[0] = 8'h10; rot[1] = 8'h11; rot[2] = 8'h12; rot[3] = 8'h13; rot[4] = 8'h10;
        alt[0] = 8'hA1; alt[1] = 8'hA3; alt[2] = 8'hA1; alt[3] = 8'hA3;

        // Reset with everything active.
        arst_i    = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        set_data(8'h20, 8'h21, 8'h22, 8'h23);
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        req_valid = 4'b0000;
        #1;
        check("rst_idle_ready", 32'(req_ready), 32'b0000);
        arst_i = 1'b0;
        tick();
        req_valid = 4'b0110;
        #1;
        check("first_grant_ready", 32'(req_ready), 32'b0010);
        tick();
        expect_out("first_grant", 8'h21, 1);

        // Round-robin rotation.
        do_reset();
        req_valid = 4'b1111;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("rotate", rot[i], i % N);
        end

        // Pointer skip and wrap with requesters 1 and 3.
        do_reset();
        req_valid = 4'b1010;
        set_data(8'h00, 8'hA1, 8'h00, 8'hA3);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("skip_wrap", alt[i], (i % 2) ? 3 : 1);
        end

        // Backpressure: hold 0x55 for three stalled cycles.
        do_reset();
        req_valid = 4'b0001;
        set_data(8'h55, 8'h00, 8'h00, 8'h00);
        tick();
        expect_out("bp_load", 8'h55, 0);
        req_valid = 4'b1111;
        set_data(8'h60, 8'h61, 8'h62, 8'h63);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready_zero", 32'(req_ready), 32'b0000);
            tick();
            expect_out("bp_hold", 8'h55, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_ready", 32'(req_ready), 32'b0010);
        tick();
        expect_out("bp_resume", 8'h61, 1);

        // Idle: valid drops one cycle after the last consume, data is kept.
        req_valid = 4'b0000;
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_data", 32'(out_data), 32'h61);
        tick();
        check("idle_valid2", 32'(out_valid), 32'd0);

        // Async reset in the middle of the rotation stream.
        do_reset();
        req_valid = 4'b1111;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        tick();
        tick();
        expect_out("mid_pre", 8'h11, 1);
        arst_i = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'h00);
        tick();
        arst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("mid_restart", rot[i], i);
        end

        // Randomized traffic; the falling-edge process compares every cycle.
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < N; j++) req_data[j] = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                arst_i = 1'b1;
                tick();
                arst_i = 1'b0;
            end else begin
                tick();
            end
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_mux.md
# rr_arbiter_mux

Round-robin N:1 arbiter and data multiplexer with a registered valid/ready output stage. Each cycle it selects one valid requester, builds a one-hot grant, masks every request payload with its grant bit and OR-reduces the masked payloads through `or_reduction` to form the selected word. The result is captured in a single output register. It sits in front of shared single-port consumers such as a write-back port or a memory request channel, where several producers compete for one slot per cycle.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `DATA_WIDTH`, default 64: payload width in bits.

Ports:
- `clk_i`, input, 1: clock, rising edge.
- `arst_i`, input, 1: reset, asynchronous and active-high.
- `req_data_i`, input, `[DATA_WIDTH-1:0] [NUM_REQ]`: per-requester payload.
- `req_valid_i`, input, `[NUM_REQ-1:0]`: per-requester valid.
- `req_ready_o`, output, `[NUM_REQ-1:0]`: per-requester ready, one-hot or zero.
- `out_data_o`, output, `DATA_WIDTH`: registered selected payload.
- `out_valid_o`, output, 1: output valid.
- `out_ready_i`, input, 1: downstream ready.

## Operation
- Priority pointer `ptr`, `$clog2(NUM_REQ)` bits, reset 0.
- Arbitration is combinational. Scan indices `ptr`, `ptr+1`, … with wrap modulo `NUM_REQ`. The first index with `req_valid_i` set wins (`w`).
  - `grant` is one-hot at `w`.
  - `grant` is all-zero if no requester is valid.
- Masked data: element i = `req_data_i[i]` if `grant[i]`, else 0. The selected word is the OR-reduction of the masked array.
- `load = !out_valid_o || out_ready_i`.
- `req_ready_o = grant & {NUM_REQ{load}}`.
  - `req_ready_o` depends combinationally on `req_valid_i` and `out_ready_i`.
  - A requester must not make its valid depend on its ready.
- Input transfer: `req_valid_i[w] && req_ready_o[w]`. At most one transfer per cycle.
- On `load`:
  - `out_valid_o <= |req_valid_i`.
  - If a transfer occurs, `out_data_o <=` selected word.
  - If no transfer occurs, `out_data_o` holds its value.
- On `!load` (output stalled): `out_valid_o` and `out_data_o` hold; all `req_ready_o` are 0.
- Pointer update: on transfer, `ptr <= (w == NUM_REQ-1) ? 0 : w+1`. Otherwise `ptr` holds.
  - Result: a requester that was just served has lowest priority next cycle.
  - Fairness: a continuously valid requester is served within `NUM_REQ` transfers.
- Output handshake: word consumed when `out_valid_o && out_ready_i`. Once `out_valid_o` is high, `out_data_o` stays stable until consumed.

## Timing
- Reset values: `out_valid_o` = 0, `out_data_o` = 0, `ptr` = 0. `req_ready_o` = 0 while no request is valid.
- Reset is asynchronous: asserting `arst_i` mid-transfer clears state immediately and discards any held output word.
- Latency: 1 cycle from input transfer to `out_valid_o`.
- Throughput: 1 word/cycle while `out_ready_i` = 1.
- Simultaneous consume and load: in the same cycle the output word is consumed and a new word is loaded. There is no bubble.
- Output stall: `out_ready_i` = 0 with `out_valid_o` = 1 blocks all requesters. The pointer does not move.
- Single requester: the same index may win on consecutive cycles. Wrap from `NUM_REQ-1` to 0 is handled by the pointer rule.

## Configuration
- Macro `RR_ARBITER_MUX_IDX_EN`.
- Defined: adds output port `out_idx_o`, `$clog2(NUM_REQ)` bits.
  - Registered alongside `out_data_o`; holds the index of the requester whose word is in the output register.
  - Reset value 0; holds under the same conditions as `out_data_o`.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
All scenarios use `NUM_REQ` = 4, `DATA_WIDTH` = 8.
1. Reset
   - Stimulus: assert `arst_i` with all inputs active.
   - Required: `out_valid_o` = 0, `out_data_o` = 0x00, `req_ready_o` = 0 on the next cycle after release only where the rules allow.
   - Required: first grant goes to the lowest valid index.
2. Round-robin rotation
   - Stimulus: all four valid, data `{0x10, 0x11, 0x12, 0x13}`, `out_ready_i` = 1.
   - Required: output sequence 0x10, 0x11, 0x12, 0x13, 0x10, one word per cycle starting one cycle after the first grant.
3. Pointer skip and wrap
   - Stimulus: only requesters 1 and 3 valid, payloads 0xA1 and 0xA3.
   - Required: outputs alternate 0xA3, 0xA1 after 0xA1 is served first. `ptr` wraps 3→0 and scans to 1.
4. Backpressure
   - Stimulus: `out_ready_i` = 0 for 3 cycles with `out_valid_o` = 1 holding 0x55.
   - Required: `out_data_o` stays 0x55, `req_ready_o` = 0, `ptr` unchanged.
   - Required: on `out_ready_i` = 1, the next grant goes to the same winner as before the stall.
5. Idle and bubble
   - Stimulus: no requester valid while `out_ready_i` = 1.
   - Required: `out_valid_o` drops to 0 one cycle after the last consume. `out_data_o` keeps the last word.
6. Async reset mid-stream, and index port
   - Stimulus: assert `arst_i` during scenario 2, then release.
   - Required: `out_valid_o` goes to 0 immediately. Arbitration restarts from index 0.
   - Required with `RR_ARBITER_MUX_IDX_EN` defined: `out_idx_o` tracks 0, 1, 2, 3 alongside the data.
